// File: rtl/pipe_ctrl.sv
// Control pipeline for a four-stage CPU datapath: decodes instructions on entry to D,
// carries their controls through E/M/W, stalls on RAW hazards and squashes on taken beq.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        zero,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [15:0] id_imm16,
  output logic        id_alu_source,
  output logic        id_branch,
  output logic [1:0]  ex_alu_ctrl,
  output logic        mem_mem_write,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_write_addr,
  output logic        branch_taken,
  output logic        illegal
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        alu_source;
    logic        branch;
    logic [1:0]  alu_ctrl;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  write_addr;
    logic        reads_rs;
    logic        reads_rt;
  } dstage_t;

  dstage_t    d_stage, dec;
  logic       d_illegal, dec_illegal;

  logic       e_valid, e_branch, e_mem_write, e_reg_write, e_mem_to_reg;
  logic [1:0] e_alu_ctrl;
  logic [4:0] e_write_addr;

  logic       m_valid, m_mem_write, m_reg_write, m_mem_to_reg;
  logic [4:0] m_write_addr;

  logic       w_reg_write, w_mem_to_reg;
  logic [4:0] w_write_addr;

  logic       stall;
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    dec             = '0;
    dec_illegal     = 1'b0;
    dec.valid       = 1'b1;
    dec.rs          = instr[25:21];
    dec.rt          = instr[20:16];
    dec.rd          = instr[15:11];
    dec.imm16       = instr[15:0];
    dec.reads_rs    = 1'b1;
    case (opcode)
      6'b000000: begin
        dec.reads_rt   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.write_addr = instr[15:11];
        case (funct)
          6'b100000: dec.alu_ctrl = 2'b00;
          6'b100010: dec.alu_ctrl = 2'b01;
          6'b100100: dec.alu_ctrl = 2'b10;
          6'b100101: dec.alu_ctrl = 2'b11;
          default:   dec_illegal  = 1'b1;
        endcase
      end
      6'b001000: begin
        dec.alu_source = 1'b1;
        dec.reg_write  = 1'b1;
        dec.write_addr = instr[20:16];
      end
      6'b100011: begin
        dec.alu_source = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.write_addr = instr[20:16];
      end
      6'b101011: begin
        dec.reads_rt   = 1'b1;
        dec.alu_source = 1'b1;
        dec.mem_write  = 1'b1;
      end
      6'b000100: begin
        dec.reads_rt = 1'b1;
        dec.branch   = 1'b1;
        dec.alu_ctrl = 2'b01;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Writes to $0 are discarded, so they never count as a producer.
    if (dec.write_addr == 5'd0)
      dec.reg_write = 1'b0;
    if (dec_illegal)
      dec = '0;
  end

  function automatic logic pending_write(input logic [4:0] src,
                                         input logic ev, input logic ew, input logic [4:0] ea,
                                         input logic mv, input logic mw, input logic [4:0] ma);
    return (src != 5'd0) && ((ev && ew && (ea == src)) || (mv && mw && (ma == src)));
  endfunction

  // W is not checked: the register file writes on the opposite edge.
  assign stall = d_stage.valid &&
                 ((d_stage.reads_rs && pending_write(d_stage.rs, e_valid, e_reg_write, e_write_addr,
                                                     m_valid, m_reg_write, m_write_addr)) ||
                  (d_stage.reads_rt && pending_write(d_stage.rt, e_valid, e_reg_write, e_write_addr,
                                                     m_valid, m_reg_write, m_write_addr)));

  assign branch_taken = e_valid & e_branch & zero;
  assign instr_ready  = ~stall & ~branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_stage      <= '0;
      d_illegal    <= 1'b0;
      e_valid      <= 1'b0;
      e_branch     <= 1'b0;
      e_mem_write  <= 1'b0;
      e_reg_write  <= 1'b0;
      e_mem_to_reg <= 1'b0;
      e_alu_ctrl   <= 2'b00;
      e_write_addr <= 5'd0;
      m_valid      <= 1'b0;
      m_mem_write  <= 1'b0;
      m_reg_write  <= 1'b0;
      m_mem_to_reg <= 1'b0;
      m_write_addr <= 5'd0;
      w_reg_write  <= 1'b0;
      w_mem_to_reg <= 1'b0;
      w_write_addr <= 5'd0;
    end else begin
      w_reg_write  <= m_reg_write;
      w_mem_to_reg <= m_mem_to_reg;
      w_write_addr <= m_write_addr;
      m_valid      <= e_valid;
      m_mem_write  <= e_mem_write;
      m_reg_write  <= e_reg_write;
      m_mem_to_reg <= e_mem_to_reg;
      m_write_addr <= e_write_addr;
      // A stalled D or a squashed younger instruction leaves a bubble in E.
      if (stall || branch_taken) begin
        e_valid      <= 1'b0;
        e_branch     <= 1'b0;
        e_mem_write  <= 1'b0;
        e_reg_write  <= 1'b0;
        e_mem_to_reg <= 1'b0;
        e_alu_ctrl   <= 2'b00;
        e_write_addr <= 5'd0;
      end else begin
        e_valid      <= d_stage.valid;
        e_branch     <= d_stage.branch;
        e_mem_write  <= d_stage.mem_write;
        e_reg_write  <= d_stage.reg_write;
        e_mem_to_reg <= d_stage.mem_to_reg;
        e_alu_ctrl   <= d_stage.alu_ctrl;
        e_write_addr <= d_stage.write_addr;
      end
      if (branch_taken) begin
        d_stage   <= '0;
        d_illegal <= 1'b0;
      end else if (!stall) begin
        if (instr_valid) begin
          d_stage   <= dec;
          d_illegal <= dec_illegal;
        end else begin
          d_stage   <= '0;
          d_illegal <= 1'b0;
        end
      end
    end
  end

  assign id_rs         = d_stage.rs;
  assign id_rt         = d_stage.rt;
  assign id_rd         = d_stage.rd;
  assign id_imm16      = d_stage.imm16;
  assign id_alu_source = d_stage.alu_source;
  assign id_branch     = d_stage.branch;
  assign illegal       = d_illegal;
  assign ex_alu_ctrl   = e_alu_ctrl;
  assign mem_mem_write = m_mem_write;
  assign wb_reg_write  = w_reg_write;
  assign wb_mem_to_reg = w_mem_to_reg;
  assign wb_write_addr = w_write_addr;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes hand-computed expected events with
// their due cycle; a negedge monitor pops and compares whenever the DUT presents them.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        zero;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;
  logic        id_alu_source, id_branch;
  logic [1:0]  ex_alu_ctrl;
  logic        mem_mem_write, wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_write_addr;
  logic        branch_taken, illegal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int cyc; logic [4:0] wa; logic m2r;} wb_t;
  typedef struct {int cyc; logic [1:0] alu;} ex_t;
  wb_t wb_q[$];
  ex_t ex_q[$];
  int  mem_q[$];
  int  br_q[$];
  int  ill_q[$];

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero(zero),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm16(id_imm16),
    .id_alu_source(id_alu_source), .id_branch(id_branch), .ex_alu_ctrl(ex_alu_ctrl),
    .mem_mem_write(mem_mem_write), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_write_addr(wb_write_addr),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  // Monitor: pop an expectation whenever the DUT presents the matching event.
  always @(negedge clk) begin
    wb_t w;
    int  c;
    if (!reset) begin
      if (wb_reg_write) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected cyc=%0d got addr=%0d", cyc, wb_write_addr);
        end else begin
          w = wb_q.pop_front();
          if (w.cyc != cyc || w.wa != wb_write_addr || w.m2r != wb_mem_to_reg) begin
            errors++;
            $display("FAIL wb got cyc=%0d addr=%0d m2r=%0d want cyc=%0d addr=%0d m2r=%0d",
                     cyc, wb_write_addr, wb_mem_to_reg, w.cyc, w.wa, w.m2r);
          end
        end
      end
      if (mem_mem_write) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected cyc=%0d", cyc);
        end else begin
          c = mem_q.pop_front();
          if (c != cyc) begin
            errors++;
            $display("FAIL mem_write got cyc=%0d want cyc=%0d", cyc, c);
          end
        end
      end
      if (branch_taken) begin
        checks++;
        if (br_q.size() == 0) begin
          errors++;
          $display("FAIL branch_unexpected cyc=%0d", cyc);
        end else begin
          c = br_q.pop_front();
          if (c != cyc) begin
            errors++;
            $display("FAIL branch_taken got cyc=%0d want cyc=%0d", cyc, c);
          end
        end
      end
      if (illegal) begin
        checks++;
        if (ill_q.size() == 0) begin
          errors++;
          $display("FAIL illegal_unexpected cyc=%0d", cyc);
        end else begin
          c = ill_q.pop_front();
          if (c != cyc) begin
            errors++;
            $display("FAIL illegal got cyc=%0d want cyc=%0d", cyc, c);
          end
        end
      end
      if (ex_q.size() != 0 && ex_q[0].cyc <= cyc) begin
        checks++;
        if (ex_q[0].cyc != cyc || ex_q[0].alu != ex_alu_ctrl) begin
          errors++;
          $display("FAIL ex_alu_ctrl got cyc=%0d alu=%0d want cyc=%0d alu=%0d",
                   cyc, ex_alu_ctrl, ex_q[0].cyc, ex_q[0].alu);
        end
        void'(ex_q.pop_front());
      end
    end
  end

  // Issue one instruction; exp_wait = cycles instr_ready is low before acceptance,
  // own = stall cycles this instruction spends in D. alu < 0 means no E-stage check.
  task automatic send(input string name, input logic [31:0] ins, input int exp_wait,
                      input int own, input int alu, input logic wb, input logic [4:0] wa,
                      input logic m2r, input logic mem, input logic br, input logic ill);
    int waited = 0;
    int acc;
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && waited < 20) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited != exp_wait) begin
      errors++;
      $display("FAIL %s wait got %0d want %0d", name, waited, exp_wait);
    end
    acc = cyc;
    if (wb)      wb_q.push_back('{acc + 4 + own, wa, m2r});
    if (mem)     mem_q.push_back(acc + 3 + own);
    if (br)      br_q.push_back(acc + 2 + own);
    if (alu >= 0) ex_q.push_back('{acc + 2 + own, alu[1:0]});
    if (ill)     ill_q.push_back(acc + 1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    if (!ill) begin
      checks++;
      if (id_rs != ins[25:21] || id_rt != ins[20:16] || id_rd != ins[15:11] ||
          id_imm16 != ins[15:0]) begin
        errors++;
        $display("FAIL %s id_fields got rs=%0d rt=%0d rd=%0d imm=%h want rs=%0d rt=%0d rd=%0d imm=%h",
                 name, id_rs, id_rt, id_rd, id_imm16, ins[25:21], ins[20:16], ins[15:11], ins[15:0]);
      end
    end
    $display("txn %s accepted cyc=%0d waited=%0d", name, acc, waited);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({id_rs, id_rt, id_rd, id_imm16, id_alu_source, id_branch, ex_alu_ctrl, mem_mem_write,
         wb_reg_write, wb_mem_to_reg, wb_write_addr, branch_taken, illegal} != '0 ||
        instr_ready != 1'b1) begin
      errors++;
      $display("FAIL %s outputs not cleared: ready=%0d wb=%0d mem=%0d ill=%0d idrs=%0d want all 0, ready=1",
               name, instr_ready, wb_reg_write, mem_mem_write, illegal, id_rs);
    end
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'd0;
    instr_valid = 1'b0;
    zero = 1'b0;
    #3;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Independent instructions: no stalls, one per cycle.
    send("addi_r1", enc_i(6'h08, 5'd0, 5'd1, 16'd4), 0, 0, 0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    send("sw_r5",   enc_i(6'h2b, 5'd0, 5'd5, 16'd1), 0, 0, 0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send("addi_r2", enc_i(6'h08, 5'd0, 5'd2, 16'd3), 0, 0, 0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Back-to-back RAW: 2-cycle stall, add reaches W 7 cycles after the producer.
    send("addi_r1b", enc_i(6'h08, 5'd0, 5'd1, 16'd4), 0, 0, 0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    send("add_r3",   enc_r(5'd1, 5'd1, 5'd3, 6'h20),  0, 2, 0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Producer distance 2: 1-cycle stall.
    send("addi_r6", enc_i(6'h08, 5'd0, 5'd6, 16'd1), 0, 0, 0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    send("addi_r7", enc_i(6'h08, 5'd0, 5'd7, 16'd2), 0, 0, 0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    send("add_r8",  enc_r(5'd6, 5'd0, 5'd8, 6'h20),  0, 1, 0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Distance 3: no stall; then sub->and dependency and the follower waiting on it.
    send("addi_r9",  enc_i(6'h08, 5'd0, 5'd9, 16'd1),  0, 0, 0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0);
    send("addi_r10", enc_i(6'h08, 5'd0, 5'd10, 16'd1), 0, 0, 0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    send("addi_r11", enc_i(6'h08, 5'd0, 5'd11, 16'd1), 0, 0, 0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    send("sub_r12",  enc_r(5'd9, 5'd0, 5'd12, 6'h22),  0, 0, 1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    send("and_r13",  enc_r(5'd12, 5'd12, 5'd13, 6'h24), 0, 2, 2, 1'b1, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0);
    send("or_r14",   enc_r(5'd0, 5'd0, 5'd14, 6'h25),  2, 0, 3, 1'b1, 5'd14, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // $0 destination never writes and never creates a hazard; lw selects memory data.
    send("addi_r0", enc_i(6'h08, 5'd0, 5'd0, 16'd5), 0, 0, 0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send("add_r4",  enc_r(5'd0, 5'd0, 5'd4, 6'h20),  0, 0, 0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    send("lw_r12",  enc_i(6'h23, 5'd0, 5'd12, 16'd8), 0, 0, 0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Taken branch squashes the younger addi; the next one waits one cycle.
    zero = 1'b1;
    send("beq_taken", enc_i(6'h04, 5'd1, 5'd1, 16'd3), 0, 0, 1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    send("addi_sq",   enc_i(6'h08, 5'd0, 5'd13, 16'd1), 0, 0, -1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send("addi_r14",  enc_i(6'h08, 5'd0, 5'd14, 16'd1), 1, 0, 0, 1'b1, 5'd14, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Not-taken branch: younger addi completes.
    zero = 1'b0;
    send("beq_nt",   enc_i(6'h04, 5'd1, 5'd1, 16'd3), 0, 0, 1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    send("addi_r15", enc_i(6'h08, 5'd0, 5'd15, 16'd1), 0, 0, 0, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Illegal opcode and illegal funct travel as bubbles; then 3 idle cycles.
    send("ill_op",    32'hFC000000, 0, 0, -1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    send("ill_funct", enc_r(5'd1, 5'd2, 5'd3, 6'h2a), 0, 0, -1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    idle(4);

    // Reset asserted between edges while D is stalled; nothing in flight may retire.
    instr = enc_i(6'h08, 5'd0, 5'd1, 16'd4);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr = enc_r(5'd1, 5'd1, 5'd3, 6'h20);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_before_reset ready got %0d want 0", instr_ready);
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_stall");
    $display("txn reset_mid_stall cyc=%0d", cyc);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    send("addi_r5_post", enc_i(6'h08, 5'd0, 5'd5, 16'd9), 0, 0, 0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);

    checks++;
    if (wb_q.size() != 0) begin errors++; $display("FAIL wb_pending left=%0d want 0", wb_q.size()); end
    checks++;
    if (mem_q.size() != 0) begin errors++; $display("FAIL mem_pending left=%0d want 0", mem_q.size()); end
    checks++;
    if (br_q.size() != 0) begin errors++; $display("FAIL br_pending left=%0d want 0", br_q.size()); end
    checks++;
    if (ill_q.size() != 0) begin errors++; $display("FAIL ill_pending left=%0d want 0", ill_q.size()); end
    checks++;
    if (ex_q.size() != 0) begin errors++; $display("FAIL ex_pending left=%0d want 0", ex_q.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
